pc_redirect_ctrl: RTL and testbench

- Control-flow redirect controller for the fetch stage.
- Accepts resolved branch and jump requests from execute.
- Registers the winning target and drives the select and target inputs of the next-PC mux (0 = sequential PC, 1 = redirect target).
- Asserts a pipeline flush for a fixed number of cycles after each redirect and holds the redirect across fetch stalls.

---
 rtl/pc_redirect_ctrl.sv | 95 +++++++++
 tb/tb_pc_redirect_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_ctrl.sv
// Fetch-stage redirect controller: registers the winning branch/jump target, drives the
// next-PC mux select and a fixed-length flush. Optional macro: PC_MISALIGN_TRAP_EN.
module pc_redirect_ctrl #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_valid,
    input  logic             br_taken,
    input  logic [XLEN-1:0]  br_target,
    input  logic             jmp_valid,
    input  logic [XLEN-1:0]  jmp_target,
    input  logic             fetch_stall,
    output logic             pc_sel,
    output logic [XLEN-1:0]  pc_target,
    output logic             flush,
    output logic [CNT_W-1:0] redirect_count,
    output logic             misalign_err
);

    typedef enum logic [1:0] {StIdle, StIssue, StFlush} state_e;

    state_e      state_q;
    logic [3:0]  flush_cnt_q;
    logic        req;
    logic        misaligned;
    logic [XLEN-1:0] req_target;

    assign req        = jmp_valid | (br_valid & br_taken);
    assign req_target = jmp_valid ? jmp_target : br_target;

`ifdef PC_MISALIGN_TRAP_EN
    assign misaligned = (req_target[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            flush_cnt_q    <= 4'd0;
            pc_sel         <= 1'b0;
            pc_target      <= '0;
            flush          <= 1'b0;
            redirect_count <= '0;
            misalign_err   <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        if (misaligned) begin
                            misalign_err <= 1'b1;
                        end else begin
                            pc_target <= req_target;
                            pc_sel    <= 1'b1;
                            flush     <= 1'b1;
                            state_q   <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    // Hold the redirect until the PC register actually loads it.
                    if (!fetch_stall) begin
                        redirect_count <= redirect_count + CNT_W'(1);
                        pc_sel         <= 1'b0;
                        if (FLUSH_CYCLES == 1) begin
                            flush   <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            flush_cnt_q <= 4'(FLUSH_CYCLES - 2);
                            state_q     <= StFlush;
                        end
                    end
                end
                StFlush: begin
                    if (flush_cnt_q == 4'd0) begin
                        flush   <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    pc_sel  <= 1'b0;
                    flush   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: two instances (flush length 2 and 4) checked every cycle
// against a cycle-count model, plus directed literal expectations on the first instance.
module tb_pc_redirect_ctrl;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned FC0   = 2;
    localparam int unsigned FC1   = 4;
`ifdef PC_MISALIGN_TRAP_EN
    localparam bit Trap = 1'b1;
`else
    localparam bit Trap = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic br_valid, br_taken, jmp_valid, fetch_stall;
    logic [XLEN-1:0] br_target, jmp_target;

    logic             pc_sel [2];
    logic [XLEN-1:0]  pc_target [2];
    logic             flush [2];
    logic [CNT_W-1:0] rcount [2];
    logic             mis [2];

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    always #5 clk = ~clk;

    pc_redirect_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC0), .CNT_W(CNT_W)) dut0 (
        .clk(clk), .rst(rst), .br_valid(br_valid), .br_taken(br_taken),
        .br_target(br_target), .jmp_valid(jmp_valid), .jmp_target(jmp_target),
        .fetch_stall(fetch_stall), .pc_sel(pc_sel[0]), .pc_target(pc_target[0]),
        .flush(flush[0]), .redirect_count(rcount[0]), .misalign_err(mis[0])
    );

    pc_redirect_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FC1), .CNT_W(CNT_W)) dut1 (
        .clk(clk), .rst(rst), .br_valid(br_valid), .br_taken(br_taken),
        .br_target(br_target), .jmp_valid(jmp_valid), .jmp_target(jmp_target),
        .fetch_stall(fetch_stall), .pc_sel(pc_sel[1]), .pc_target(pc_target[1]),
        .flush(flush[1]), .redirect_count(rcount[1]), .misalign_err(mis[1])
    );

    // Model: a pending redirect flag plus the number of flush cycles still owed after the take.
    bit              m_pending [2];
    int              m_left [2];
    logic [XLEN-1:0] m_tgt [2];
    int              m_cnt [2];
    bit              m_mis [2];
    int              fc [2] = '{FC0, FC1};

    always @(posedge clk or posedge rst) begin
        logic [XLEN-1:0] t;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_pending[i] = 1'b0;
                m_left[i]    = 0;
                m_tgt[i]     = '0;
                m_cnt[i]     = 0;
                m_mis[i]     = 1'b0;
            end else begin
                m_mis[i] = 1'b0;
                if (m_pending[i]) begin
                    if (!fetch_stall) begin
                        m_cnt[i]     = (m_cnt[i] + 1) % (1 << CNT_W);
                        m_pending[i] = 1'b0;
                        m_left[i]    = fc[i] - 1;
                    end
                end else if (m_left[i] > 0) begin
                    m_left[i] = m_left[i] - 1;
                end else if (jmp_valid || (br_valid && br_taken)) begin
                    t = jmp_valid ? jmp_target : br_target;
                    if (Trap && t[1:0] != 2'b00) begin
                        m_mis[i] = 1'b1;
                    end else begin
                        m_pending[i] = 1'b1;
                        m_tgt[i]     = t;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run_cmp && !rst) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("m%0d.pc_sel", i), 32'(pc_sel[i]), 32'(m_pending[i]));
                chk($sformatf("m%0d.flush", i), 32'(flush[i]),
                    32'(m_pending[i] || m_left[i] > 0));
                chk($sformatf("m%0d.pc_target", i), pc_target[i], m_tgt[i]);
                chk($sformatf("m%0d.count", i), 32'(rcount[i]), 32'(m_cnt[i]));
                chk($sformatf("m%0d.misalign", i), 32'(mis[i]), 32'(m_mis[i]));
            end
        end
    end

    task automatic cyc(input bit bv, input bit bt, input logic [31:0] bta,
                       input bit jv, input logic [31:0] jta, input bit st);
        br_valid    = bv;
        br_taken    = bt;
        br_target   = bta;
        jmp_valid   = jv;
        jmp_target  = jta;
        fetch_stall = st;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        br_valid = 1'b0; br_taken = 1'b0; br_target = '0;
        jmp_valid = 1'b0; jmp_target = '0; fetch_stall = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_cmp = 1'b1;
        chk("reset.pc_sel", 32'(pc_sel[0]), 32'd0);
        chk("reset.flush", 32'(flush[0]), 32'd0);
        chk("reset.count", 32'(rcount[0]), 32'd0);

        // Basic taken branch
        cyc(1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
        chk("br.pc_sel", 32'(pc_sel[0]), 32'd1);
        chk("br.target", pc_target[0], 32'h100);
        chk("br.flush", 32'(flush[0]), 32'd1);
        idle();
        chk("br.take.pc_sel", 32'(pc_sel[0]), 32'd0);
        chk("br.take.flush", 32'(flush[0]), 32'd1);
        idle();
        chk("br.done.flush", 32'(flush[0]), 32'd0);
        chk("br.done.count", 32'(rcount[0]), 32'd1);

        // Jump beats a same-cycle taken branch
        cyc(1'b1, 1'b1, 32'h300, 1'b1, 32'h200, 1'b0);
        chk("prio.target", pc_target[0], 32'h200);
        chk("prio.pc_sel", 32'(pc_sel[0]), 32'd1);
        idle();
        idle();
        chk("prio.count", 32'(rcount[0]), 32'd2);

        // Not-taken branch is not a request
        cyc(1'b1, 1'b0, 32'h700, 1'b0, 32'h0, 1'b0);
        chk("nt.pc_sel", 32'(pc_sel[0]), 32'd0);
        chk("nt.flush", 32'(flush[0]), 32'd0);
        chk("nt.count", 32'(rcount[0]), 32'd2);

        // Stalled redirect, with wrong-path jumps during ISSUE and FLUSH
        cyc(1'b1, 1'b1, 32'h400, 1'b0, 32'h0, 1'b0);
        chk("stall.pc_sel0", 32'(pc_sel[0]), 32'd1);
        chk("stall.target0", pc_target[0], 32'h400);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h500, 1'b1);
            chk($sformatf("stall.pc_sel%0d", k + 1), 32'(pc_sel[0]), 32'd1);
            chk($sformatf("stall.target%0d", k + 1), pc_target[0], 32'h400);
            chk($sformatf("stall.count%0d", k + 1), 32'(rcount[0]), 32'd2);
        end
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h500, 1'b0);
        chk("take.pc_sel", 32'(pc_sel[0]), 32'd0);
        chk("take.flush", 32'(flush[0]), 32'd1);
        chk("take.count", 32'(rcount[0]), 32'd3);
        chk("take.target", pc_target[0], 32'h400);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h500, 1'b0);
        chk("lastflush.pc_sel", 32'(pc_sel[0]), 32'd0);
        chk("lastflush.flush", 32'(flush[0]), 32'd0);
        chk("lastflush.count", 32'(rcount[0]), 32'd3);
        chk("lastflush.target", pc_target[0], 32'h400);
        idle();

        // Counter wrap: 3 + 5 redirects modulo 8
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h1000 + 32'(16 * k), 1'b0);
            idle();
            idle();
        end
        chk("wrap.count", 32'(rcount[0]), 32'd0);

        // Misaligned jump target
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h202, 1'b0);
`ifdef PC_MISALIGN_TRAP_EN
        chk("mis.err", 32'(mis[0]), 32'd1);
        chk("mis.pc_sel", 32'(pc_sel[0]), 32'd0);
        chk("mis.flush", 32'(flush[0]), 32'd0);
        idle();
        chk("mis.err_clear", 32'(mis[0]), 32'd0);
        chk("mis.count", 32'(rcount[0]), 32'd0);
`else
        chk("mis.err", 32'(mis[0]), 32'd0);
        chk("mis.pc_sel", 32'(pc_sel[0]), 32'd1);
        chk("mis.target", pc_target[0], 32'h202);
        idle();
        idle();
        chk("mis.count", 32'(rcount[0]), 32'd1);
`endif

        // Asynchronous reset in the middle of ISSUE
        repeat (4) idle();
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h600, 1'b0);
        chk("arst.pre.pc_sel", 32'(pc_sel[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst.pc_sel", 32'(pc_sel[0]), 32'd0);
        chk("arst.target", pc_target[0], 32'h0);
        chk("arst.flush", 32'(flush[0]), 32'd0);
        chk("arst.count", 32'(rcount[0]), 32'd0);
        chk("arst.misalign", 32'(mis[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        jmp_valid = 1'b0;

        // Random traffic, checked by the model on both instances
        repeat (400) begin
            logic [31:0] ma, mb;
            ma = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC;
            mb = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC;
            cyc(1'($urandom), 1'($urandom), $urandom & ma,
                1'($urandom_range(0, 3) == 0), $urandom & mb,
                1'($urandom_range(0, 2) == 0));
        end

        run_cmp = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
